// File: rtl/ibr128_pkg.sv
// Shared types for the IBR128 engine arbiter: FSM states, block width, response record.
package ibr128_pkg;

    localparam int IBR128_BW = 128;
    localparam int ID_MAXW   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_MAXW-1:0]   id;
        logic [IBR128_BW-1:0] data;
        logic                 err;
    } resp_t;

endpackage

// File: rtl/ibr128_core_arb_if.sv
// Request, response and engine-side signals of the IBR128 arbiter, bundled with directional views.
interface ibr128_core_arb_if
    import ibr128_pkg::*;
#(
    parameter int NREQ = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0]           req_encrypt;
    logic [NREQ-1:0]           req_sa;
    logic [NREQ*IBR128_BW-1:0] req_data;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [IDW-1:0]            resp_id;
    logic [IBR128_BW-1:0]      resp_data;
    logic                      resp_err;
    logic                      core_start;
    logic                      core_encrypt;
    logic                      core_sa;
    logic [IBR128_BW-1:0]      core_pdata;
    logic                      core_ready;
    logic [IBR128_BW-1:0]      core_edata;
    logic                      busy;

    // Arbiter side.
    modport slave (
        input  req_valid, req_encrypt, req_sa, req_data, resp_ready, core_ready, core_edata,
        output req_ready, resp_valid, resp_id, resp_data, resp_err,
               core_start, core_encrypt, core_sa, core_pdata, busy
    );

    // Requesters plus engine side.
    modport master (
        output req_valid, req_encrypt, req_sa, req_data, resp_ready, core_ready, core_edata,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err,
               core_start, core_encrypt, core_sa, core_pdata, busy
    );

endinterface

// File: rtl/ibr128_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, wrapping.
module ibr128_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] cand;

    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/ibr128_core_arb.sv
// Round-robin scheduler sharing one IBR128 block engine among NREQ requesters, with a job watchdog.
module ibr128_core_arb
    import ibr128_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               Clk,
    input  logic               RstN,
    ibr128_core_arb_if.slave   bus
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [IDW-1:0]       ptr;
    logic [WDW-1:0]       wd;
    resp_t                resp;
    logic                 resp_valid;
    logic                 core_start;
    logic                 core_encrypt;
    logic                 core_sa;
    logic [IBR128_BW-1:0] core_pdata;
    logic [NREQ-1:0]      req_ready;
    logic                 busy;
    logic                 wd_hit;
    logic                 pick_any;
    logic [NREQ-1:0]      pick_grant;
    logic [IDW-1:0]       pick_idx;
    logic                 unused_id;

    ibr128_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .any   (pick_any),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign wd_hit = (wd == WD_LAST);

    always_ff @(posedge Clk) begin
        if (!RstN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = RstN ? pick_grant : '0;
                if (pick_any) state_nxt = WAIT;
            end
            // A completion in the watchdog's last cycle still counts as success.
            WAIT:    if (bus.core_ready || wd_hit) state_nxt = RESP;
            RESP:    if (resp_valid && bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            ptr          <= IDW'(NREQ - 1);
            wd           <= '0;
            core_start   <= 1'b0;
            core_encrypt <= 1'b0;
            core_sa      <= 1'b0;
            core_pdata   <= '0;
            resp_valid   <= 1'b0;
            resp         <= '0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    core_encrypt <= bus.req_encrypt[pick_idx];
                    core_sa      <= bus.req_sa[pick_idx];
                    core_pdata   <= bus.req_data[int'(pick_idx)*IBR128_BW +: IBR128_BW];
                    resp.id      <= ID_MAXW'(pick_idx);
                    wd           <= '0;
                    core_start   <= 1'b1;
                end
                WAIT: begin
                    wd <= wd + WDW'(1);
                    if (bus.core_ready) begin
                        resp.data  <= bus.core_edata;
                        resp.err   <= 1'b0;
                        core_start <= 1'b0;
                        resp_valid <= 1'b1;
                    end else if (wd_hit) begin
                        resp.data  <= '0;
                        resp.err   <= 1'b1;
                        core_start <= 1'b0;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: if (bus.resp_ready) begin
                    resp_valid <= 1'b0;
                    ptr        <= resp.id[IDW-1:0];
                end
                default: ;
            endcase
        end
    end

    assign unused_id        = ^resp.id;
    assign bus.req_ready    = req_ready;
    assign bus.busy         = busy;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_id      = resp.id[IDW-1:0];
    assign bus.resp_data    = resp.data;
    assign bus.resp_err     = resp.err;
    assign bus.core_start   = core_start;
    assign bus.core_encrypt = core_encrypt;
    assign bus.core_sa      = core_sa;
    assign bus.core_pdata   = core_pdata;

endmodule

// File: tb/tb_ibr128_core_arb.sv
// Bench for ibr128_core_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_ibr128_core_arb;
    import ibr128_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam logic [IBR128_BW-1:0] ONES = '1;
    localparam logic [IBR128_BW-1:0] T1_DATA = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [IBR128_BW-1:0] T1_RES  = 128'hFEDCBA9876543210FEDCBA9876543210;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    bit   armed = 0;
    int   eng_delay = 5;

    ibr128_core_arb_if #(.NREQ(NREQ)) bus ();

    ibr128_core_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk  (clk),
        .RstN (rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [IBR128_BW-1:0] act, input logic [IBR128_BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [IBR128_BW-1:0] rand128();
        logic [IBR128_BW-1:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Winner = valid requester at the smallest circular distance past the last winner.
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        int best;
        int bestd;
        int dd;
        best  = -1;
        bestd = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            dd = (j - last - 1 + 2*NREQ) % NREQ;
            if (v[j] && dd < bestd) begin
                best  = j;
                bestd = dd;
            end
        end
        return best;
    endfunction

    // Engine model: answers data^ones in the eng_delay-th cycle of core_start (0 = first), never if <0.
    int e_cnt = 0;
    int e_cap = 0;
    initial begin
        bus.core_ready = 1'b0;
        bus.core_edata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.core_start) begin
                if (e_cnt == 0) e_cap = eng_delay;
                e_cnt++;
                if (e_cap >= 0 && e_cnt == e_cap + 1) begin
                    bus.core_ready = 1'b1;
                    bus.core_edata = bus.core_pdata ^ ONES;
                end else begin
                    bus.core_ready = 1'b0;
                    bus.core_edata = rand128();
                end
            end else begin
                e_cnt = 0;
                bus.core_ready = 1'($urandom_range(0, 1));
                bus.core_edata = rand128();
            end
        end
    end

    // Transaction-level model and per-cycle comparison.
    bit                   m_active  = 0;
    int                   m_last    = NREQ - 1;
    int                   m_id      = 0;
    logic [IBR128_BW-1:0] m_data    = '0;
    logic [IBR128_BW-1:0] m_rdata   = '0;
    logic                 m_enc     = 1'b0;
    logic                 m_sa      = 1'b0;
    logic                 m_rerr    = 1'b0;
    longint               cyc       = 0;
    longint               m_resp_at = 0;
    int                   low_run   = 0;
    bit                   gap_armed = 0;
    logic                 prev_start = 1'b0;
    int                   cmp_g;
    int                   cmp_d;
    logic [NREQ-1:0]      exp_rr;
    bit                   in_resp;

    initial begin
        forever begin
            @(negedge clk);
            cmp_g   = pick(bus.req_valid, m_last);
            exp_rr  = (!m_active && rst_n && cmp_g >= 0) ? (NREQ'(1) << cmp_g) : '0;
            in_resp = m_active && (cyc >= m_resp_at);
            if (armed) begin
                chk("req_ready",    bus.req_ready,    exp_rr);
                chk("busy",         bus.busy,         m_active);
                chk("core_start",   bus.core_start,   m_active && !in_resp);
                chk("resp_valid",   bus.resp_valid,   in_resp);
                chk("core_pdata",   bus.core_pdata,   m_data);
                chk("core_encrypt", bus.core_encrypt, m_enc);
                chk("core_sa",      bus.core_sa,      m_sa);
                if (in_resp) begin
                    chk("resp_id",   bus.resp_id,   m_id);
                    chk("resp_data", bus.resp_data, m_rdata);
                    chk("resp_err",  bus.resp_err,  m_rerr);
                end
                if (bus.core_start && !prev_start) begin
                    if (gap_armed) chk("start_gap", low_run >= 2, 1'b1);
                    gap_armed = 0;
                    low_run   = 0;
                end else if (!bus.core_start) begin
                    low_run++;
                end
            end
            prev_start = bus.core_start;

            if (!rst_n) begin
                m_active  = 0;
                m_last    = NREQ - 1;
                m_data    = '0;
                m_enc     = 1'b0;
                m_sa      = 1'b0;
                gap_armed = 0;
            end else if (!m_active) begin
                if (cmp_g >= 0) begin
                    m_active  = 1;
                    m_id      = cmp_g;
                    m_data    = bus.req_data[IBR128_BW*cmp_g +: IBR128_BW];
                    m_enc     = bus.req_encrypt[cmp_g];
                    m_sa      = bus.req_sa[cmp_g];
                    cmp_d     = eng_delay;
                    m_rerr    = (cmp_d < 0 || cmp_d > TIMEOUT - 1);
                    m_resp_at = cyc + (m_rerr ? TIMEOUT - 1 : cmp_d) + 2;
                    m_rdata   = m_rerr ? '0 : (m_data ^ ONES);
                end
            end else if (in_resp && bus.resp_ready) begin
                m_active  = 0;
                m_last    = m_id;
                gap_armed = 1;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic accept_one(output int g);
        int n;
        n = 0;
        g = -1;
        #1;
        while (bus.req_ready == '0 && n < 60) begin
            tick();
            n++;
        end
        if (bus.req_ready == '0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req_ready stayed %b for %0d cycles", bus.req_ready, n);
        end else begin
            for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) g = j;
        end
        tick();
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!bus.resp_valid) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: resp_valid=%b after %0d cycles", bus.resp_valid, lat);
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NREQ*4; i++) bus.req_data[32*i +: 32] = $urandom;
        bus.req_encrypt = NREQ'($urandom);
        bus.req_sa      = NREQ'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_core_start"}, bus.core_start,   0);
        chk({tag, "_resp_valid"}, bus.resp_valid,   0);
        chk({tag, "_busy"},       bus.busy,         0);
        chk({tag, "_req_ready"},  bus.req_ready,    0);
        chk({tag, "_pdata"},      bus.core_pdata,   0);
        chk({tag, "_encrypt"},    bus.core_encrypt, 0);
        chk({tag, "_sa"},         bus.core_sa,      0);
        chk({tag, "_resp_data"},  bus.resp_data,    0);
        chk({tag, "_resp_err"},   bus.resp_err,     0);
        chk({tag, "_resp_id"},    bus.resp_id,      0);
    endtask

    logic [IBR128_BW-1:0] saved;

    initial begin
        int g;
        int lat;
        rst_n           = 1'b0;
        bus.req_valid   = '0;
        bus.req_encrypt = '0;
        bus.req_sa      = '0;
        bus.req_data    = '0;
        bus.resp_ready  = 1'b1;
        eng_delay       = 5;
        repeat (3) tick();
        armed = 1;
        bus.req_valid = '1;
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        bus.req_valid = '0;
        tick();

        // Single job from requester 2.
        bus.req_valid = 4'b0100;
        bus.req_data[2*IBR128_BW +: IBR128_BW] = T1_DATA;
        bus.req_encrypt = 4'b0100;
        eng_delay = 5;
        #1;
        chk("t1_req_ready", bus.req_ready, 4'b0100);
        accept_one(g);
        bus.req_valid = '0;
        #1;
        chk("t1_ready_once", bus.req_ready, 0);
        chk("t1_pdata", bus.core_pdata, T1_DATA);
        chk("t1_encrypt", bus.core_encrypt, 1);
        wait_resp(lat);
        chk("t1_latency", lat + 1, 7);
        chk("t1_resp_id", bus.resp_id, 2);
        chk("t1_resp_data", bus.resp_data, T1_RES);
        chk("t1_resp_err", bus.resp_err, 0);
        tick();

        // Fairness under full load.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req_valid = '1;
        for (int j = 0; j < 8; j++) begin
            rand_inputs();
            eng_delay = $urandom_range(0, 8);
            accept_one(g);
            chk("fair_grant", g, j % NREQ);
            wait_resp(lat);
            tick();
        end

        // Skip idle requesters after a grant to 3.
        bus.req_valid = 4'b0110;
        accept_one(g);
        chk("skip_first", g, 1);
        wait_resp(lat);
        tick();
        accept_one(g);
        chk("skip_second", g, 2);
        wait_resp(lat);
        tick();

        // Watchdog abort.
        bus.req_valid = 4'b0001;
        eng_delay = -1;
        accept_one(g);
        chk("wd_grant", g, 0);
        bus.req_valid = '0;
        wait_resp(lat);
        chk("wd_latency", lat + 1, TIMEOUT + 1);
        chk("wd_err", bus.resp_err, 1);
        chk("wd_data", bus.resp_data, 0);
        chk("wd_core_start", bus.core_start, 0);
        tick();

        // Backpressure with completion in the watchdog's last cycle.
        bus.resp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        saved = rand128();
        bus.req_data[1*IBR128_BW +: IBR128_BW] = saved;
        eng_delay = TIMEOUT - 1;
        accept_one(g);
        chk("tie_grant", g, 1);
        bus.req_valid = '1;
        wait_resp(lat);
        chk("tie_latency", lat + 1, TIMEOUT + 1);
        chk("tie_err", bus.resp_err, 0);
        chk("tie_data", bus.resp_data, saved ^ ONES);
        repeat (10) begin
            tick();
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_valid", bus.resp_valid, 1);
            chk("bp_data", bus.resp_data, saved ^ ONES);
            chk("bp_id", bus.resp_id, 1);
        end
        bus.resp_ready = 1'b1;
        tick();
        #1;
        chk("bp_release", bus.req_ready, 4'b0100);

        // Reset in the middle of WAIT.
        eng_delay = 8;
        accept_one(g);
        chk("mid_grant", g, 2);
        repeat (3) tick();
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        bus.req_valid = 4'b1000;
        eng_delay = 4;
        accept_one(g);
        chk("post_rst_grant", g, 3);
        bus.req_valid = '0;
        wait_resp(lat);
        chk("post_rst_latency", lat + 1, 6);
        chk("post_rst_id", bus.resp_id, 3);
        tick();

        // Random traffic, backpressure, engine delays and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            bus.req_valid  = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            rand_inputs();
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            eng_delay      = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
            rst_n          = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
